ifetch_unit: RTL and testbench
==============================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL provide: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL provide: reset  input  1  asynchronous, active-low reset; asserting it forces reset state immediately, independent of clk.
REQ-003 SHALL provide: pc_addr  input  32  current fetch address from PC register.
REQ-004 SHALL provide: pc_en  output  1  PC load enable; high only in the cycle a fetch is issued.
REQ-005 SHALL provide: flush  input  1  discard queued and outstanding fetches.
REQ-006 SHALL provide: imem_req  output  1, imem_addr  output  32  memory request and word address.
REQ-007 SHALL provide: imem_ack  input  1, imem_rdata  input  32  memory completion and instruction word.
REQ-008 SHALL provide: instr_valid  output  1, instr  output  32, instr_pc  output  32, instr_exc  output  1  head-of-queue instruction to decode.
REQ-009 SHALL provide: instr_ready  input  1  decode consumes head when instr_valid and instr_ready both high.

Function
REQ-010 SHALL hold a 2-entry FIFO of {pc, instr, exc}; outputs driven from head entry; instr_valid = FIFO non-empty.
REQ-011 SHALL use states IDLE, REQ, DROP, HALT.
REQ-012 SHALL issue a fetch when in IDLE (or REQ with imem_ack this cycle), flush low, and entries after this cycle's push/pop plus new request <= 2.
REQ-013 On issue: pc_en = 1 combinationally; imem_addr <= pc_addr; imem_req <= 1; next state REQ.
REQ-014 imem_req and imem_addr SHALL stay stable in REQ until imem_ack is sampled high.
REQ-015 On imem_ack in REQ: push {imem_addr, imem_rdata, 0}; if no new issue, imem_req <= 0 and state IDLE.
REQ-016 Latency: ack sampled at edge N makes instr_valid high after edge N; zero-wait memory with ready consumer SHALL sustain one instruction per cycle.
REQ-017 Simultaneous push and pop with FIFO full SHALL be legal; count unchanged, order preserved.
REQ-018 imem_ack outside REQ/DROP SHALL be ignored.
REQ-019 flush SHALL clear FIFO (instr_valid low next cycle), block issue that cycle, force pc_en 0.
REQ-020 flush in REQ without ack SHALL go to DROP with imem_req held; in DROP, ack is discarded, imem_req <= 0, state IDLE.
REQ-021 flush with imem_ack same cycle SHALL discard the data and go to IDLE.
REQ-022 flush in HALT SHALL return to IDLE.

Reset
REQ-023 On reset low: state IDLE, FIFO empty, imem_req 0, imem_addr 0x00003000, instr_valid 0, instr 0x00000000, instr_pc 0x00003000, instr_exc 0, pc_en 0.
REQ-024 Reset mid-transaction SHALL abandon the outstanding request; a later stray imem_ack SHALL be ignored per REQ-018.

Configuration
REQ-025 Macro IFETCH_ADDR_CHECK_EN defined: an issuable pc_addr with pc_addr[1:0] != 0 or outside 0x00003000..0x00006FFF SHALL issue no memory request, push {pc_addr, 0x00000000, 1}, keep pc_en 0, enter HALT; HALT issues nothing until flush.
REQ-026 Macro undefined: no address check, instr_exc constant 0, HALT unreachable.

Verification
REQ-027 Reset release, pc_addr 0x3000, imem_ack same cycle as req, instr_ready 1 -> instr 0x3000's word valid one cycle after ack; steady one-per-cycle with pc_en high each cycle.
REQ-028 instr_ready 0, zero-wait memory -> exactly 2 entries fill, imem_req drops, pc_en 0; raise ready -> fetch resumes in order.
REQ-029 Req at 0x3004, ack delayed 3 cycles -> imem_req/imem_addr 0x3004 stable 3 cycles, then instr_pc 0x3004 valid.
REQ-030 flush while req 0x3008 outstanding, ack 2 cycles later -> DROP; acked data never appears; instr_valid 0 from cycle after flush.
REQ-031 With IFETCH_ADDR_CHECK_EN, pc_addr 0x3002 -> no imem_req, instr_exc 1, instr_pc 0x3002, HALT until flush; without macro -> normal fetch.
REQ-032 Reset low asynchronously mid-REQ -> all outputs reach REQ-023 values without a clock edge.

Source files
------------

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch front end.
// Issues one word fetch at a time to instruction memory, tracks the
// outstanding request through IDLE/REQ/DROP/HALT, and buffers returned
// words in a 2-entry FIFO whose head is presented to decode.
// Optional build macro IFETCH_ADDR_CHECK_EN: misaligned or out-of-window
// fetch addresses produce an exception entry instead of a memory request
// and park the unit in HALT until a flush.
module ifetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_addr,
  output logic        pc_en,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_exc,
  input  logic        instr_ready
);

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] ADDR_LO  = 32'h0000_3000;
  localparam logic [31:0] ADDR_HI  = 32'h0000_6FFF;

  typedef enum logic [1:0] {IDLE, REQ, DROP, HALT} state_t;

  state_t      state;

  logic [31:0] fifo_pc    [2];
  logic [31:0] fifo_instr [2];
  logic        fifo_exc   [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic        bad_addr;
  logic        push_mem;
  logic        pop;
  logic [2:0]  cnt_after;
  logic        can_issue;
  logic        issue_mem;
  logic        issue_exc;
  logic        exc_slot;

`ifdef IFETCH_ADDR_CHECK_EN
  assign bad_addr = (pc_addr[1:0] != 2'b00) || (pc_addr < ADDR_LO) || (pc_addr > ADDR_HI);
`else
  assign bad_addr = 1'b0;
`endif

  // Head of the FIFO is what decode sees.
  assign instr_valid = (count != 2'd0);
  assign instr       = fifo_instr[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];
  assign instr_exc   = fifo_exc[rd_ptr];

  assign pop      = instr_valid && instr_ready;
  assign push_mem = (state == REQ) && imem_ack && !flush;

  // Occupancy after this cycle's memory push and decode pop; a new fetch
  // needs one free slot on top of that so its response always has room.
  assign cnt_after = {1'b0, count} + {2'b00, push_mem} - {2'b00, pop};
  assign can_issue = reset && !flush && ((state == IDLE) || push_mem) &&
                     (cnt_after <= 3'd1);
  assign issue_mem = can_issue && !bad_addr;
  assign issue_exc = can_issue && bad_addr;
  assign pc_en     = issue_mem;

  // When a memory word and an exception entry land together, the exception
  // goes in the slot after the memory word.
  assign exc_slot = push_mem ? ~wr_ptr : wr_ptr;

  // Fetch control FSM: owns the memory request and its address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (issue_mem) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc_addr;
          end else if (issue_exc) begin
            state <= HALT;
          end
        end
        REQ: begin
          if (flush) begin
            if (imem_ack) begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end else begin
              state <= DROP;
            end
          end else if (imem_ack) begin
            if (issue_mem) begin
              imem_addr <= pc_addr;
            end else begin
              imem_req <= 1'b0;
              state    <= issue_exc ? HALT : IDLE;
            end
          end
        end
        DROP: begin
          if (imem_ack) begin
            state    <= IDLE;
            imem_req <= 1'b0;
          end
        end
        HALT: begin
          if (flush) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-entry instruction FIFO: up to two writes and one read per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        fifo_pc[i]    <= RESET_PC;
        fifo_instr[i] <= 32'h0000_0000;
        fifo_exc[i]   <= 1'b0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_mem) begin
        fifo_pc[wr_ptr]    <= imem_addr;
        fifo_instr[wr_ptr] <= imem_rdata;
        fifo_exc[wr_ptr]   <= 1'b0;
      end
      if (issue_exc) begin
        fifo_pc[exc_slot]    <= pc_addr;
        fifo_instr[exc_slot] <= 32'h0000_0000;
        fifo_exc[exc_slot]   <= 1'b1;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      wr_ptr <= wr_ptr ^ push_mem ^ issue_exc;
      count  <= cnt_after[1:0] + {1'b0, issue_exc};
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed bench for ifetch_unit with a scoreboard queue.
// Memory returns {16'hC0DE, addr[15:0]} for every word address.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_addr;
  logic        pc_en;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_exc;
  logic        instr_ready;

  logic        zw;
  logic        ack_force;
  logic        en_s;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        exc;
  } ent_t;

  ent_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   consumed    = 0;

  always #5 clk = ~clk;

  assign imem_ack   = zw ? imem_req : ack_force;
  assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

  ifetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .pc_addr    (pc_addr),
    .pc_en      (pc_en),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_exc  (instr_exc),
    .instr_ready(instr_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic expect_word(input logic [31:0] pc);
    exp_q.push_back('{pc: pc, ins: {16'hC0DE, pc[15:0]}, exc: 1'b0});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_imem_req"},    {31'd0, imem_req},    32'd0);
    check({tag, "_imem_addr"},   imem_addr,            32'h3000);
    check({tag, "_instr_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_instr"},       instr,                32'h0);
    check({tag, "_instr_pc"},    instr_pc,             32'h3000);
    check({tag, "_instr_exc"},   {31'd0, instr_exc},   32'd0);
    check({tag, "_pc_en"},       {31'd0, pc_en},       32'd0);
  endtask

  // Sample point in the middle of a cycle; also captures pc_en for the PC model.
  task automatic mid();
    @(negedge clk);
    en_s = pc_en;
  endtask

  // Just after the rising edge: the PC register advances if the fetch was taken.
  task automatic tick();
    @(posedge clk);
    #1;
    if (en_s) pc_addr = pc_addr + 32'd4;
  endtask

  task automatic step();
    mid();
    tick();
  endtask

  task automatic wait_consumed(input int n);
    int guard;
    guard = 0;
    while (consumed < n && guard < 200) begin
      step();
      guard++;
    end
    check("consume_budget", consumed, n);
  endtask

  // Monitor: every decode handshake pops one expected entry.
  initial begin : monitor
    ent_t e;
    forever begin
      @(negedge clk);
      if (reset && instr_valid && instr_ready) begin
        consumed++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_unexpected: got pc %h, expected no entry", instr_pc);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc",    instr_pc,             e.pc);
          check("sb_instr", instr,                e.ins);
          check("sb_exc",   {31'd0, instr_exc},   {31'd0, e.exc});
        end
      end
    end
  end

  initial begin : stim
    reset       = 1'b0;
    pc_addr     = 32'h3000;
    flush       = 1'b0;
    instr_ready = 1'b0;
    zw          = 1'b1;
    ack_force   = 1'b0;
    en_s        = 1'b0;

    #12;
    check_reset_vals("rst");

    // Zero-wait memory, ready consumer: one instruction per cycle.
    @(posedge clk); #1;
    reset       = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) expect_word(32'h3000 + 32'(4 * i));
    mid();
    check("c0_pc_en", {31'd0, pc_en}, 32'd1);
    check("c0_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    mid();
    check("c1_pc_en",  {31'd0, pc_en}, 32'd1);
    check("c1_valid",  {31'd0, instr_valid}, 32'd0);
    check("c1_req",    {31'd0, imem_req}, 32'd1);
    check("c1_addr",   imem_addr, 32'h3000);
    tick();
    mid();
    check("c2_valid",  {31'd0, instr_valid}, 32'd1);
    check("c2_pc_en",  {31'd0, pc_en}, 32'd1);
    tick();
    mid();
    check("c3_pc_en",  {31'd0, pc_en}, 32'd1);
    tick();
    wait_consumed(6);

    // Stalled decode: FIFO fills to two and fetching stops.
    instr_ready = 1'b0;
    repeat (3) step();
    mid();
    check("full_req",   {31'd0, imem_req}, 32'd0);
    check("full_pc_en", {31'd0, pc_en}, 32'd0);
    check("full_valid", {31'd0, instr_valid}, 32'd1);
    check("full_head",  instr_pc, 32'h3018);
    tick();
    expect_word(32'h3018);
    expect_word(32'h301C);
    expect_word(32'h3020);
    expect_word(32'h3024);
    instr_ready = 1'b1;
    wait_consumed(10);
    instr_ready = 1'b0;
    repeat (3) step();

    // Flush with a full FIFO, then a slow memory.
    flush   = 1'b1;
    pc_addr = 32'h3004;
    zw      = 1'b0;
    mid();
    check("fl_pc_en", {31'd0, pc_en}, 32'd0);
    check("fl_valid", {31'd0, instr_valid}, 32'd1);
    tick();
    flush = 1'b0;
    mid();
    check("fl_after_valid", {31'd0, instr_valid}, 32'd0);
    check("fl_after_pc_en", {31'd0, pc_en}, 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      mid();
      check("wait_req",   {31'd0, imem_req}, 32'd1);
      check("wait_addr",  imem_addr, 32'h3004);
      check("wait_pc_en", {31'd0, pc_en}, 32'd0);
      tick();
    end
    ack_force = 1'b1;
    mid();
    check("ack_pc_en", {31'd0, pc_en}, 32'd1);
    tick();
    ack_force = 1'b0;
    mid();
    check("slow_valid", {31'd0, instr_valid}, 32'd1);
    check("slow_pc",    instr_pc, 32'h3004);
    check("slow_instr", instr, 32'hC0DE3004);
    check("slow_next",  imem_addr, 32'h3008);
    tick();

    // Flush with 0x3008 outstanding; its late ack must be discarded.
    flush = 1'b1;
    mid();
    check("drop_pc_en", {31'd0, pc_en}, 32'd0);
    check("drop_req",   {31'd0, imem_req}, 32'd1);
    tick();
    flush = 1'b0;
    mid();
    check("drop1_valid", {31'd0, instr_valid}, 32'd0);
    check("drop1_req",   {31'd0, imem_req}, 32'd1);
    check("drop1_addr",  imem_addr, 32'h3008);
    tick();
    ack_force = 1'b1;
    mid();
    check("drop2_valid", {31'd0, instr_valid}, 32'd0);
    check("drop2_pc_en", {31'd0, pc_en}, 32'd0);
    tick();
    ack_force = 1'b0;
    mid();
    check("drop3_valid", {31'd0, instr_valid}, 32'd0);
    check("drop3_req",   {31'd0, imem_req}, 32'd0);
    check("drop3_pc_en", {31'd0, pc_en}, 32'd1);
    tick();
    mid();
    check("pre_rst_req",  {31'd0, imem_req}, 32'd1);
    check("pre_rst_addr", imem_addr, 32'h300C);

    // Asynchronous reset in the middle of an outstanding request.
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("arst");
    tick();
    reset     = 1'b1;
    flush     = 1'b1;
    ack_force = 1'b1;
    mid();
    check("stray_req",   {31'd0, imem_req}, 32'd0);
    check("stray_valid", {31'd0, instr_valid}, 32'd0);
    check("stray_pc_en", {31'd0, pc_en}, 32'd0);
    tick();
    flush       = 1'b0;
    ack_force   = 1'b0;
    zw          = 1'b1;
    instr_ready = 1'b1;
    pc_addr     = 32'h3002;

`ifdef IFETCH_ADDR_CHECK_EN
    // Misaligned address: exception entry, no request, HALT until flush.
    exp_q.push_back('{pc: 32'h3002, ins: 32'h0, exc: 1'b1});
    mid();
    check("chk_pc_en", {31'd0, pc_en}, 32'd0);
    check("chk_req",   {31'd0, imem_req}, 32'd0);
    tick();
    mid();
    check("chk_valid", {31'd0, instr_valid}, 32'd1);
    check("chk_exc",   {31'd0, instr_exc}, 32'd1);
    check("chk_pc",    instr_pc, 32'h3002);
    tick();
    wait_consumed(11);
    mid();
    check("halt_req",   {31'd0, imem_req}, 32'd0);
    check("halt_pc_en", {31'd0, pc_en}, 32'd0);
    check("halt_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    flush   = 1'b1;
    pc_addr = 32'h3010;
    step();
    flush = 1'b0;
    mid();
    check("unhalt_pc_en", {31'd0, pc_en}, 32'd1);
    tick();
`else
    // No address check: a misaligned address is fetched like any other.
    expect_word(32'h3002);
    expect_word(32'h3006);
    expect_word(32'h300A);
    mid();
    check("nochk_pc_en", {31'd0, pc_en}, 32'd1);
    tick();
    mid();
    check("nochk_req",  {31'd0, imem_req}, 32'd1);
    check("nochk_addr", imem_addr, 32'h3002);
    tick();
    wait_consumed(13);
`endif

    instr_ready = 1'b0;
    repeat (2) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("sb_drain", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
